// File: rtl/hot_pulse_checker.sv
// Receive-side checker for a periodic single-cycle pulse train.
// Locks onto the pulse phase and flags missed or early pulses.
module hot_pulse_checker #(
  parameter int PERIOD     = 4,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int GAP_W  = $clog2(PERIOD);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [GOOD_W-1:0]  good, good_n;
  logic               err_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               due;
  logic [GOOD_W-1:0]  good_inc;

  assign due      = (gap == GAP_W'(PERIOD - 1));
  assign good_inc = good + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEARCH;
      gap       <= '0;
      good      <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      gap       <= gap_n;
      good      <= good_n;
      err       <= err_n;
      err_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap;
    good_n  = good;
    err_n   = 1'b0;
    cnt_n   = err_count;
    unique case (state)
      SEARCH: begin
        if (x) begin
          state_n = TRACK;
          gap_n   = '0;
          good_n  = '0;
        end
      end
      TRACK, LOCKED: begin
        if (x && due) begin
          gap_n = '0;
          if (state == TRACK) begin
            good_n = good_inc;
            if (good_inc == GOOD_W'(LOCK_COUNT))
              state_n = LOCKED;
          end
        end else if (x || due) begin
          // early pulse re-phases to TRACK; a missed one drops to SEARCH
          err_n   = 1'b1;
          state_n = x ? TRACK : SEARCH;
          gap_n   = '0;
          good_n  = '0;
          if (err_count != {CNT_W{1'b1}})
            cnt_n = err_count + 1'b1;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
        gap_n   = '0;
        good_n  = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_hot_pulse_checker.sv
// Directed bench for hot_pulse_checker.
// Edge numbers count rising edges since reset was last released.
module tb_hot_pulse_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  logic       reset2 = 1'b0;
  logic       x2 = 1'b0;
  logic       locked2;
  logic       err2;
  logic [1:0] err_count2;

  int tests = 0;
  int fails = 0;
  int e = 0;

  always #5 clk = ~clk;

  hot_pulse_checker #(.PERIOD(4), .LOCK_COUNT(2), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .locked(locked),
    .err(err),
    .err_count(err_count)
  );

  hot_pulse_checker #(.PERIOD(4), .LOCK_COUNT(2), .CNT_W(2)) dut2 (
    .clk(clk),
    .reset(reset2),
    .x(x2),
    .locked(locked2),
    .err(err2),
    .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h",
             tag, e, obs, exp);
    end
  endtask

  task automatic tick(input logic xv, input logic rv);
    x = xv;
    reset = rv;
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic chk3(input string tag, input logic l, input logic r,
                      input logic [7:0] c);
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".err"}, 32'(err), 32'(r));
    chk({tag, ".cnt"}, 32'(err_count), 32'(c));
  endtask

  // pulses where edge%4==pmod, up to edge 'last'; no errors expected
  task automatic seg(input string tag, input int last, input int pmod,
                     input int lock_at, input logic [7:0] c);
    while (e < last) begin
      tick(((e + 1) % 4) == pmod, 1'b1);
      chk3(tag, e >= lock_at, 1'b0, c);
    end
  endtask

  task automatic do_reset(input string tag);
    tick(1'b1, 1'b0);
    chk3(tag, 1'b0, 1'b0, 8'd0);
    e = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tick(i[0], 1'b0);
      chk3("reset", 1'b0, 1'b0, 8'd0);
    end
    e = 0;

    seg("clean", 19, 3, 11, 8'd0);

    seg("miss_pre", 22, 3, 11, 8'd0);
    tick(1'b0, 1'b1);
    chk3("miss", 1'b0, 1'b1, 8'd1);
    seg("miss_rec", 35, 3, 35, 8'd1);

    tick(1'b0, 1'b0);
    chk3("rst_locked", 1'b0, 1'b0, 8'd0);
    e = 36;
    seg("rst_rec", 48, 0, 48, 8'd0);

    do_reset("rst_x1");
    tick(1'b1, 1'b1);
    chk3("first_at_release", 1'b0, 1'b0, 8'd0);
    seg("release_rec", 9, 1, 9, 8'd0);

    do_reset("rst_early");
    seg("early_pre", 20, 3, 11, 8'd0);
    tick(1'b1, 1'b1);
    chk3("early", 1'b0, 1'b1, 8'd1);
    seg("early_rec", 29, 1, 29, 8'd1);

    x = 1'b0;
    reset = 1'b0;
    x2 = 1'b1;
    reset2 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk("sat.cnt", 32'(err_count2), (k - 1 > 3) ? 32'd3 : 32'(k - 1));
      chk("sat.err", 32'(err2), 32'(k > 1));
      chk("sat.locked", 32'(locked2), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hot_pulse_checker.md
# hot_pulse_checker

Receive-side checker for the single-cycle "hot" pulse train produced by the quiz pulse generators. It samples a one-bit pulse input, locks onto a fixed pulse period, and then flags every missed or early pulse. It sits directly after a pulse source in the bench or design and reports `locked`, a one-cycle `err` strobe and a saturating error count.

## Interface

- `PERIOD`, 4, cycles between consecutive pulses (pulse-to-pulse distance); must be at least 2.
- `LOCK_COUNT`, 2, consecutive on-time pulses required after the first pulse to reach LOCKED; must be at least 1.
- `CNT_W`, 8, width of `err_count`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset: `reset=0` sampled on a rising edge clears all state.
- `x`  in  1  pulse input, sampled on every rising edge.
- `locked`  out  1  high while the FSM is in LOCKED.
- `err`  out  1  one-cycle strobe for a missed or early pulse.
- `err_count`  out  CNT_W  saturating count of `err` strobes.

## Operation

- Internal registers:
  - `state` ∈ {SEARCH, TRACK, LOCKED}.
  - `gap`: cycles since the last accepted pulse, width clog2(PERIOD).
  - `good`: on-time pulse count, wide enough to hold LOCK_COUNT.
- Reset (`reset=0` at an edge) takes priority over `x`. It sets `state=SEARCH`, `gap=0`, `good=0`, `locked=0`, `err=0`, `err_count=0`.
- SEARCH:
  - `x=0`: hold.
  - `x=1`: go to TRACK, `gap<=0`, `good<=0`. The first pulse is never an error.
- TRACK or LOCKED, evaluated every edge:
  - `x=1` with `gap==PERIOD-1` (on time):
    - `gap<=0`.
    - In TRACK: `good<=good+1`; if `good+1==LOCK_COUNT`, go to LOCKED.
    - In LOCKED: stay in LOCKED.
  - `x=1` with `gap!=PERIOD-1` (early):
    - `err<=1`, increment `err_count`.
    - Go to TRACK with `good<=0`, `gap<=0`; the early pulse becomes the new phase reference.
  - `x=0` with `gap==PERIOD-1` (missed):
    - `err<=1`, increment `err_count`.
    - Go to SEARCH with `good<=0`, `gap<=0`.
  - `x=0` otherwise: `gap<=gap+1`.
- `err` is 0 on every edge that does not flag an error, so it is never high for more than one cycle per event.
- `err_count` saturates at 2^CNT_W-1 and never wraps. `err` still strobes at saturation.
- `x` held high continuously after the first pulse: every following edge is an early pulse, so `err=1` every cycle and the block stays in TRACK.

## Timing

- All outputs are registered. `locked`, `err` and `err_count` change on the same edge that samples the causing `x` value and are visible during the following cycle.
- Lock latency from the first pulse, for a clean train: LOCK_COUNT×PERIOD cycles.
- Missed-pulse detection fires on the edge where a pulse was due (gap reaches PERIOD-1 with `x=0`). There is no extra delay.
- Reset mid-operation (including while LOCKED or while `err=1`) clears all outputs on that edge. Pulses sampled while `reset=0` are ignored.
- `reset` deasserted with `x=1` on the same edge: the pulse is accepted as the first pulse of SEARCH.

## Test plan

Defaults apply (PERIOD=4, LOCK_COUNT=2) unless stated otherwise.

- Reset: hold `reset=0` for 3 edges while toggling `x` -> `locked=0`, `err=0`, `err_count=0` throughout.
- Clean lock: pulses at edges 3, 7, 11, 15, 19 -> `locked=1` after edge 11 and stays 1; `err` never 1; `err_count=0`.
- Missed pulse:
  - Stimulus: locked as above, omit the pulse at edge 23.
  - Required: after edge 23, `err=1` for one cycle, `err_count=1`, `locked=0`.
  - Recovery: pulses at 27, 31, 35 give `locked=1` after edge 35.
- Early pulse:
  - Stimulus: locked with the last pulse at edge 19, extra pulse at edge 21.
  - Required: after edge 21, `err=1`, `err_count=1`, `locked=0`.
  - Recovery: pulses at 25 and 29 give `locked=1` after edge 29; the old-phase pulse at 23 is not sent.
- Saturation: CNT_W=2 with `x` held at 1 for 10 edges -> `err_count` goes 1, 2, 3, then stays 3; `err=1` every edge after the first.
- Reset while locked: `reset=0` for one edge at edge 20 -> after that edge `locked=0`, `err_count=0`. Pulses resumed at edges 24, 28, 32 (edge 24 is the first pulse) give `locked=1` after edge 32.
